gpio_in_conditioner: RTL and testbench



---
 rtl/gpio_in_conditioner.sv | 93 +++++++++
 tb/tb_gpio_in_conditioner.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gpio_in_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gpio_in_conditioner                                                      |
// | Per-pin synchronizer, debounce filter, edge detect and sticky IRQ flags. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module gpio_in_conditioner #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      pad_in,
  input  logic [DEBOUNCE_W-1:0] debounce_cycles,
  input  logic [WIDTH-1:0]      filt_en,
  input  logic [WIDTH-1:0]      irq_rise_en,
  input  logic [WIDTH-1:0]      irq_fall_en,
  input  logic [WIDTH-1:0]      pending_clr,
  output logic [WIDTH-1:0]      gpio_read,
  output logic [WIDTH-1:0]      rise,
  output logic [WIDTH-1:0]      fall,
  output logic [WIDTH-1:0]      pending,
  output logic                  irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0]     sync_q, sync_d;
  logic [WIDTH-1:0][DEBOUNCE_W-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]                      gpio_read_q, gpio_read_d;
  logic [WIDTH-1:0]                      prev_q, prev_d;
  logic [WIDTH-1:0]                      pending_q, pending_d;
  logic [WIDTH-1:0]                      s;
  logic [DEBOUNCE_W-1:0]                 thr;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = pad_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Threshold compares against N-1 with >=, so a lowered N applies immediately
  // and the counter can never run past it.
  always_comb begin
    cnt_d       = cnt_q;
    gpio_read_d = gpio_read_q;
    thr         = '0;
    for (int i = 0; i < WIDTH; i++) begin
      thr = (filt_en[i] && (debounce_cycles != '0))
            ? debounce_cycles - DEBOUNCE_W'(1) : '0;
      if (s[i] == gpio_read_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= thr) begin
        gpio_read_d[i] = s[i];
        cnt_d[i]       = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DEBOUNCE_W'(1);
      end
    end
  end

  always_comb begin
    prev_d    = gpio_read_q;
    pending_d = (pending_q & ~pending_clr) | (rise & irq_rise_en) | (fall & irq_fall_en);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      gpio_read_q <= '0;
      prev_q      <= '0;
      pending_q   <= '0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      gpio_read_q <= gpio_read_d;
      prev_q      <= prev_d;
      pending_q   <= pending_d;
    end
  end

  assign gpio_read = gpio_read_q;
  assign rise      = gpio_read_q & ~prev_q;
  assign fall      = ~gpio_read_q & prev_q;
  assign pending   = pending_q;
  assign irq       = |pending_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_in_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gpio_in_conditioner                                                   |
// | Directed stimulus with a cycle-stamped expectation queue and monitor.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_gpio_in_conditioner;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pad_in;
  logic [15:0] debounce_cycles;
  logic [7:0]  filt_en, irq_rise_en, irq_fall_en, pending_clr;
  logic [7:0]  gpio_read, rise, fall, pending;
  logic        irq;

  gpio_in_conditioner #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_W(16)) dut (
    .clk(clk), .reset(reset), .pad_in(pad_in), .debounce_cycles(debounce_cycles),
    .filt_en(filt_en), .irq_rise_en(irq_rise_en), .irq_fall_en(irq_fall_en),
    .pending_clr(pending_clr), .gpio_read(gpio_read), .rise(rise), .fall(fall),
    .pending(pending), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] g, r, f, p;
    logic       i;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   k;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs sampled on the falling edge, compared against the entry
  // stamped for the rising edge that just occurred.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: missed sample at cyc %0d (now %0d)", e.nm, e.cyc, cyc);
      end else if (gpio_read !== e.g || rise !== e.r || fall !== e.f ||
                   pending !== e.p || irq !== e.i) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got gpio=%h rise=%h fall=%h pend=%h irq=%b, want gpio=%h rise=%h fall=%h pend=%h irq=%b",
                 e.nm, cyc, gpio_read, rise, fall, pending, irq, e.g, e.r, e.f, e.p, e.i);
      end
    end
  end

  task automatic expect_at(input int off, input logic [7:0] g, input logic [7:0] r,
                           input logic [7:0] f, input logic [7:0] p, input string nm);
    exp_t x;
    x.cyc = cyc + off; x.g = g; x.r = r; x.f = f; x.p = p; x.i = |p; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; pad_in = '0; debounce_cycles = '0; filt_en = '0;
    irq_rise_en = '0; irq_fall_en = '0; pending_clr = '0;
    tick(3);
    expect_at(1, 8'h00, 8'h00, 8'h00, 8'h00, "reset_hold");
    tick(1);
    reset = 1'b0;

    // Idle after reset
    for (int i = 1; i <= 20; i++) expect_at(i, 8'h00, 8'h00, 8'h00, 8'h00, "idle_zero");
    tick(20);

    // Bypass: filt_en low overrides a nonzero threshold
    debounce_cycles = 16'd4;
    expect_at(2, 8'h00, 8'h00, 8'h00, 8'h00, "byp_not_early");
    expect_at(3, 8'h01, 8'h01, 8'h00, 8'h00, "byp_rise");
    expect_at(4, 8'h01, 8'h00, 8'h00, 8'h00, "byp_rise_one_cycle");
    expect_at(5, 8'h01, 8'h00, 8'h00, 8'h00, "byp_no_pending");
    pad_in = 8'h01;
    tick(5);
    expect_at(3, 8'h00, 8'h00, 8'h01, 8'h00, "byp_fall");
    expect_at(4, 8'h00, 8'h00, 8'h00, 8'h00, "byp_fall_one_cycle");
    pad_in = 8'h00;
    tick(5);

    // Filtered, N=4: 3-cycle glitch rejected
    filt_en = 8'h01;
    expect_at(3, 8'h00, 8'h00, 8'h00, 8'h00, "glitch_c3");
    expect_at(5, 8'h00, 8'h00, 8'h00, 8'h00, "glitch_c5");
    expect_at(6, 8'h00, 8'h00, 8'h00, 8'h00, "glitch_c6");
    expect_at(8, 8'h00, 8'h00, 8'h00, 8'h00, "glitch_c8");
    pad_in = 8'h01;
    tick(3);
    pad_in = 8'h00;
    tick(6);

    // Filtered, N=4: 4-cycle pulse accepted at edge 6, then filtered fall
    k = cyc;
    expect_at(5,  8'h00, 8'h00, 8'h00, 8'h00, "pulse_not_early");
    expect_at(6,  8'h01, 8'h01, 8'h00, 8'h00, "pulse_rise");
    expect_at(7,  8'h01, 8'h00, 8'h00, 8'h00, "pulse_hold");
    expect_at(9,  8'h01, 8'h00, 8'h00, 8'h00, "pulse_fall_not_early");
    expect_at(10, 8'h00, 8'h00, 8'h01, 8'h00, "pulse_fall");
    expect_at(11, 8'h00, 8'h00, 8'h00, 8'h00, "pulse_quiet");
    pad_in = 8'h01;
    tick(4);
    pad_in = 8'h00;
    tick(10);

    // Pin 7 fall interrupt and write-1-to-clear
    irq_fall_en = 8'h80;
    expect_at(3, 8'h80, 8'h80, 8'h00, 8'h00, "p7_rise_no_irq");
    expect_at(4, 8'h80, 8'h00, 8'h00, 8'h00, "p7_high");
    pad_in = 8'h80;
    tick(5);
    expect_at(3, 8'h00, 8'h00, 8'h80, 8'h00, "p7_fall");
    expect_at(4, 8'h00, 8'h00, 8'h00, 8'h80, "p7_pending");
    expect_at(5, 8'h00, 8'h00, 8'h00, 8'h00, "p7_cleared");
    pad_in = 8'h00;
    tick(4);
    pending_clr = 8'h80;
    tick(1);
    pending_clr = 8'h00;
    tick(2);

    // Pin 2: set and clear coincide, set wins
    irq_rise_en = 8'h04;
    expect_at(3, 8'h04, 8'h04, 8'h00, 8'h00, "p2_rise");
    expect_at(4, 8'h04, 8'h00, 8'h00, 8'h04, "p2_set_wins");
    expect_at(5, 8'h04, 8'h00, 8'h00, 8'h04, "p2_sticky");
    expect_at(6, 8'h04, 8'h00, 8'h00, 8'h00, "p2_cleared");
    pad_in = 8'h04;
    tick(3);
    pending_clr = 8'h04;
    tick(1);
    pending_clr = 8'h00;
    tick(1);
    pending_clr = 8'h04;
    tick(1);
    pending_clr = 8'h00;
    tick(2);

    // Pin 3: threshold lowered while counting at cnt=10
    filt_en = 8'h09;
    debounce_cycles = 16'd100;
    expect_at(11, 8'h04, 8'h00, 8'h00, 8'h00, "p3_counting_a");
    expect_at(12, 8'h04, 8'h00, 8'h00, 8'h00, "p3_counting_b");
    expect_at(13, 8'h0C, 8'h08, 8'h00, 8'h00, "p3_lowered_thr");
    expect_at(14, 8'h0C, 8'h00, 8'h00, 8'h00, "p3_hold");
    pad_in = 8'h0C;
    tick(12);
    debounce_cycles = 16'd5;
    tick(4);

    tick(3);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
      n_checks += sb.size();
      n_fail   += sb.size();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
